// File: rtl/ffn_pkg.sv
// Shared state encodings, address-width defaults and a counter-width helper
// for the FFN layer sequencer.
package ffn_pkg;

  localparam int FFN_BITWIDTH    = 6;
  localparam int WEIGHT_BITWIDTH = 10;

  typedef enum logic [2:0] {
    FFN_SEQ_IDLE  = 3'd0,
    FFN_SEQ_FETCH = 3'd1,
    FFN_SEQ_BIAS  = 3'd2,
    FFN_SEQ_DRAIN = 3'd3,
    FFN_SEQ_NEXT  = 3'd4,
    FFN_SEQ_DONE  = 3'd5
  } ffn_seq_state_t;

  // A counter over n values needs at least one bit, even when n == 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ffn_wrap_counter.sv
// Enable/clear counter over 0..MAX-1 with terminal-count flag; wraps to 0
// when enabled at the terminal count. Clear has priority over enable.
module ffn_wrap_counter #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(MAX - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/ffn_layer_sequencer.sv
// Sequences one fully-connected layer over the MAC datapath: address walk,
// accumulator tagging, pipeline drain, per-neuron and layer completion.
// Optional bias term per neuron when FFN_BIAS_ADD_EN is defined.
module ffn_layer_sequencer
  import ffn_pkg::*;
#(
  parameter int IN_LEN  = 64,
  parameter int OUT_LEN = 10,
  parameter int FM_AW   = FFN_BITWIDTH,
  parameter int W_AW    = WEIGHT_BITWIDTH,
  parameter int OUT_AW  = 4,
  parameter int MAC_LAT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              buffer_rdy,
  output logic              busy,
  output logic              rd_en,
  output logic [FM_AW-1:0]  fm_addr,
  output logic [W_AW-1:0]   weight_addr,
  output logic              acc_clear,
  output logic              acc_last,
  output logic              out_valid,
  output logic [OUT_AW-1:0] out_idx,
  output logic              done
`ifdef FFN_BIAS_ADD_EN
  ,
  output logic              bias_rd,
  output logic [OUT_AW-1:0] bias_addr
`endif
);

  localparam int IW = cnt_w(IN_LEN);
  localparam int OW = cnt_w(OUT_LEN);
  localparam int DW = cnt_w(MAC_LAT);

  ffn_seq_state_t  state, state_nxt;
  logic [IW-1:0]   in_cnt;
  logic [OW-1:0]   out_cnt;
  logic [DW-1:0]   unused_drn_cnt;
  logic            in_tc, out_tc, drn_tc;
  logic            idle, fire;
  logic [W_AW-1:0] ptr;

  assign idle = (state == FFN_SEQ_IDLE);
  assign fire = (state == FFN_SEQ_FETCH) && buffer_rdy;

  ffn_wrap_counter #(.MAX(IN_LEN), .W(IW)) u_in_cnt (
    .clock(clock), .reset(reset), .clr(idle), .en(fire),
    .count(in_cnt), .tc(in_tc)
  );

  ffn_wrap_counter #(.MAX(OUT_LEN), .W(OW)) u_out_cnt (
    .clock(clock), .reset(reset), .clr(idle),
    .en((state == FFN_SEQ_NEXT) && !out_tc),
    .count(out_cnt), .tc(out_tc)
  );

  // Wraps back to 0 on its last DRAIN cycle, so every drain starts fresh.
  ffn_wrap_counter #(.MAX(MAC_LAT), .W(DW)) u_drn_cnt (
    .clock(clock), .reset(reset), .clr(idle), .en(state == FFN_SEQ_DRAIN),
    .count(unused_drn_cnt), .tc(drn_tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FFN_SEQ_IDLE:  if (start) state_nxt = FFN_SEQ_FETCH;
      FFN_SEQ_FETCH: if (fire && in_tc)
`ifdef FFN_BIAS_ADD_EN
                       state_nxt = FFN_SEQ_BIAS;
`else
                       state_nxt = FFN_SEQ_DRAIN;
`endif
      FFN_SEQ_BIAS:  state_nxt = FFN_SEQ_DRAIN;
      FFN_SEQ_DRAIN: if (drn_tc) state_nxt = FFN_SEQ_NEXT;
      FFN_SEQ_NEXT:  state_nxt = out_tc ? FFN_SEQ_DONE : FFN_SEQ_FETCH;
      FFN_SEQ_DONE:  state_nxt = FFN_SEQ_IDLE;
      default:       state_nxt = FFN_SEQ_IDLE;
    endcase
  end

  // Outputs register the action taken on this edge; addresses and indices
  // hold between strobes, pulses fall back to 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FFN_SEQ_IDLE;
      busy        <= 1'b0;
      rd_en       <= 1'b0;
      fm_addr     <= '0;
      weight_addr <= '0;
      acc_clear   <= 1'b0;
      acc_last    <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      done        <= 1'b0;
      ptr         <= '0;
`ifdef FFN_BIAS_ADD_EN
      bias_rd     <= 1'b0;
      bias_addr   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      busy      <= !idle || start;
      rd_en     <= fire;
      acc_clear <= fire && (in_cnt == '0);
      acc_last  <= fire && in_tc;
      out_valid <= (state == FFN_SEQ_NEXT);
      done      <= (state == FFN_SEQ_DONE);
      if (fire) begin
        fm_addr     <= FM_AW'(in_cnt);
        weight_addr <= ptr;
      end
      // Weight pointer runs continuously across neurons of one layer.
      if (idle)      ptr <= '0;
      else if (fire) ptr <= ptr + 1'b1;
      if (state == FFN_SEQ_NEXT) out_idx <= OUT_AW'(out_cnt);
`ifdef FFN_BIAS_ADD_EN
      bias_rd <= (state == FFN_SEQ_BIAS);
      if (state == FFN_SEQ_BIAS) bias_addr <= OUT_AW'(out_cnt);
`endif
    end
  end

endmodule
